mult_pipe: RTL
==============

# mult_pipe

Parametrised, fully pipelined RV32M/RV64M multiply functional unit for the out-of-order core. It accepts one MUL/MULH/MULHSU/MULHU operation per cycle, derives operand signedness from the function code, and carries an opaque tag (pr_idx/rob_idx/ar_idx bundle) alongside each operation. It adds per-stage valid/ready backpressure with bubble collapsing and a whole-unit squash for mispredict recovery. It sits between the issue stage and the complete stage.

## Interface
- XLEN, default 32: operand/result width; 32 or 64.
- NUM_STAGE, default 4: number of registered stages; power of two, 1..2*XLEN. Each stage consumes 2*XLEN/NUM_STAGE multiplier bits.
- TAG_W, default 16: width of the tag carried with each operation.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  unit accepts the operation on this edge.
- in_func  in  MULT_FUNC  ALU_MUL, ALU_MULH, ALU_MULHSU or ALU_MULHU.
- in_rs1  in  XLEN  multiplicand.
- in_rs2  in  XLEN  multiplier.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer takes the result on this edge.
- out_result  out  XLEN  selected product half.
- out_tag  out  TAG_W  tag of the result.
- squash  in  1  kill every in-flight operation.
- busy  out  1  at least one stage holds a valid operation.

## Operation
- Sign extension to 2*XLEN, decided from in_func:
  - ALU_MUL: no sign extension (the low half is sign-agnostic).
  - ALU_MULH: both operands signed.
  - ALU_MULHSU: rs1 signed, rs2 unsigned.
  - ALU_MULHU: both operands unsigned.
- Stage s (1..NUM_STAGE) registers the following fields: valid, func, tag, partial product, mcand, mplier.
- Per-stage step, with B = 2*XLEN/NUM_STAGE:
  - product += mcand * mplier[B-1:0], truncated to 2*XLEN bits.
  - mcand <<= B.
  - mplier >>= B.
  - Stage 1 performs this step on the extended inputs combinationally before registering.
- Result selection from stage NUM_STAGE: ALU_MUL returns bits [XLEN-1:0]. All other functions return bits [2*XLEN-1:XLEN].
- Advance rule:
  - Stage NUM_STAGE advances when !valid or out_ready.
  - Stage s<NUM_STAGE advances when stage s+1 advances or stage s+1 is empty. Bubbles therefore collapse.
  - A stage that does not advance holds all of its fields.
  - A stage that advances with no valid source loads valid=0.
- in_ready = reset & !squash & (stage 1 empty or stage 1 advances). An operation is accepted only on an edge where in_valid & in_ready.
- out_valid = stage NUM_STAGE valid & !squash. out_result and out_tag are driven from stage NUM_STAGE regardless of valid.
- Results are produced strictly in acceptance order. No operation is dropped or duplicated except by squash or reset.
- Squash: at the edge where squash=1, all valid bits clear. Nothing is accepted in that cycle, and no output handshake completes, even if out_ready=1.
- busy = OR of all stage valid bits (registered state only).

## Timing
- Reset (reset=0 at an edge):
  - All valid bits, data, func and tag registers go to 0.
  - Outputs in the cycle after reset: out_valid=0, out_result=0, out_tag=0, busy=0, in_ready=1. While reset=0, in_ready=0.
  - Reset in the middle of an operation discards everything in flight, with no late out_valid.
- Latency: an operation accepted at edge E reaches stage s at edge E+s-1. With no stalls, out_valid is high in the cycle after edge E+NUM_STAGE-1, i.e. NUM_STAGE cycles after the cycle in which it was presented.
- Throughput: 1 op/cycle while out_ready=1.
- Stall: with out_ready=0 and stage NUM_STAGE valid, out_result and out_tag are held stable. Upstream stages keep filling until each holds valid. in_ready falls only when stage 1 is valid and blocked.
- Simultaneous events:
  - Accept and output on the same edge are both legal.
  - squash wins over in_valid and out_ready.
  - reset wins over squash.
- NUM_STAGE=1: a single registered stage performs the full 2*XLEN-bit step. Latency is 1.

## Test plan
- Basic multiply and tag: XLEN=32, NUM_STAGE=4. MUL 7*6 with tag 0x1A5 -> out_valid exactly 4 cycles after presentation, out_result=42, out_tag=0x1A5.
- Function/sign coverage, each checked for result and latency:
  - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MUL 0x80000000*2 -> 0x00000000.
- Streaming: 8 back-to-back ops (i*(i+3), tags 0..7) with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, correct values, tags in order 0..7.
- Backpressure: continuous stream with out_ready=0 for 6 cycles -> in_ready low once 4 ops are held, out_result/out_tag stable while stalled. After release, every op emerges exactly once, in order.
- Squash: 3 ops in flight, squash high for 1 cycle while out_ready=1 -> no out_valid during or after the squash, busy=0 next cycle. Next op MUL 5*5 -> 25 with 4-cycle latency.
- Reset mid-flight: 2 ops in flight, reset=0 for 1 cycle -> out_valid, out_result, out_tag and busy all 0 afterwards, in_ready=1. Those 2 ops never appear.

Source files
------------

// File: rtl/mult_pipe.sv
// Pipelined RV32M/RV64M multiply unit: MUL/MULH/MULHSU/MULHU with per-stage
// valid/ready backpressure, bubble collapsing, whole-unit squash and an
// opaque tag carried alongside every operation.

package mult_pipe_pkg;
    typedef enum logic [1:0] {
        ALU_MUL    = 2'd0,
        ALU_MULH   = 2'd1,
        ALU_MULHSU = 2'd2,
        ALU_MULHU  = 2'd3
    } mult_func_t;
endpackage

module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_STAGE = 4,
    parameter int TAG_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  mult_func_t       in_func,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    input  logic             squash,
    output logic             busy
);

    localparam int W2 = 2 * XLEN;
    // Multiplier bits retired by each stage.
    localparam int B  = W2 / NUM_STAGE;
    localparam logic [W2-1:0] SLICE_MASK = {W2{1'b1}} >> (W2 - B);

    typedef struct packed {
        mult_func_t       func;
        logic [TAG_W-1:0] tag;
        logic [W2-1:0]    prod;
        logic [W2-1:0]    mcand;
        logic [W2-1:0]    mplier;
    } stage_t;

    logic [NUM_STAGE-1:0] vld;
    logic [NUM_STAGE-1:0] en;
    logic [NUM_STAGE-1:0] src_vld;
    stage_t               stg [NUM_STAGE];
    stage_t               nxt [NUM_STAGE];
    stage_t               head;

    // One radix-2^B partial-product step; truncation to W2 bits keeps the
    // two's-complement product of the extended operands exact.
    function automatic stage_t step(input stage_t s);
        stage_t r;
        r        = s;
        r.prod   = s.prod + s.mcand * (s.mplier & SLICE_MASK);
        r.mcand  = s.mcand << B;
        r.mplier = s.mplier >> B;
        return r;
    endfunction

    // Extend operands to 2*XLEN according to the signedness the function implies.
    always_comb begin
        logic sext1;
        logic sext2;
        // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
        sext1       = (in_func == ALU_MULH) || (in_func == ALU_MULHSU);
        sext2       = (in_func == ALU_MULH);
        head.func   = in_func;
        head.tag    = in_tag;
        head.prod   = '0;
        head.mcand  = {{XLEN{sext1 & in_rs1[XLEN-1]}}, in_rs1};
        head.mplier = {{XLEN{sext2 & in_rs2[XLEN-1]}}, in_rs2};
    end

    // Candidate contents for each stage: its source advanced by one step.
    always_comb begin
        nxt[0]     = step(head);
        src_vld    = '0;
        src_vld[0] = in_valid;
        for (int s = 1; s < NUM_STAGE; s++) begin
            nxt[s]     = step(stg[s-1]);
            src_vld[s] = vld[s-1];
        end
    end

    // A stage may load when the consumer drains the tail or any stage at or
    // after it is empty; this collapses bubbles without a ripple chain.
    always_comb begin
        en = '0;
        for (int s = 0; s < NUM_STAGE; s++) begin
            en[s] = out_ready ||
                    ((vld | ({NUM_STAGE{1'b1}} >> (NUM_STAGE - s))) != {NUM_STAGE{1'b1}});
        end
    end

    // Pipeline registers: reset clears everything, squash clears valids only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vld <= '0;
            // NOTE: the stage data is cleared on reset because out_result/out_tag are visible regardless of valid.
            for (int s = 0; s < NUM_STAGE; s++) begin
                stg[s] <= '0;
            end
        end else if (squash) begin
            vld <= '0;
        end else begin
            for (int s = 0; s < NUM_STAGE; s++) begin
                if (en[s]) begin
                    // NOTE: non-blocking so every stage samples its source's pre-edge value.
                    vld[s] <= src_vld[s];
                    if (src_vld[s]) begin
                        stg[s] <= nxt[s];
                    end
                end
            end
        end
    end

    assign in_ready   = reset && !squash && en[0];
    assign out_valid  = vld[NUM_STAGE-1] && !squash;
    assign out_result = (stg[NUM_STAGE-1].func == ALU_MUL) ? stg[NUM_STAGE-1].prod[XLEN-1:0]
                                                           : stg[NUM_STAGE-1].prod[W2-1:XLEN];
    assign out_tag    = stg[NUM_STAGE-1].tag;
    assign busy       = |vld;

endmodule
